// File: rtl/md_ctrl.sv
// md_ctrl: owns HI/LO and sequences multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO
// writes, raising a stall while a HI/LO result is still in flight.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, lo_q, pend_hi_q, pend_lo_q, pend_hi_d, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;
    logic          md_op, is_div, ovf;
    logic signed [63:0] smul;
    logic [63:0]   umul;
    logic [31:0]   sdiv_b, udiv_b, sq, sr, uq, ur;

    assign md_op  = start && op >= 3'd1 && op <= 3'd4;
    assign is_div = op == 3'd3 || op == 3'd4;
    // Forcing the divisor to 1 on overflow yields exactly LO=a, HI=0 for 0x80000000/-1.
    assign ovf    = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;

    always_comb begin
        smul      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul      = {32'b0, a} * {32'b0, b};
        sdiv_b    = (b == 32'd0 || ovf) ? 32'd1 : b;
        udiv_b    = (b == 32'd0) ? 32'd1 : b;
        sq        = $signed(a) / $signed(sdiv_b);
        sr        = $signed(a) % $signed(sdiv_b);
        uq        = a / udiv_b;
        ur        = a % udiv_b;
        pend_hi_d = op == 3'd1 ? smul[63:32] : op == 3'd2 ? umul[63:32] : op == 3'd3 ? sr : ur;
        pend_lo_d = op == 3'd1 ? smul[31:0]  : op == 3'd2 ? umul[31:0]  : op == 3'd3 ? sq : uq;
        pend_wr_d = !(is_div && b == 32'd0);
        cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (md_op) begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                pend_wr_q <= pend_wr_d;
                cnt_q     <= cnt_d;
                state_q   <= RUN;
            end else if (start && op == 3'd5) begin
                hi_q <= a;
            end else if (start && op == 3'd6) begin
                lo_q <= a;
            end
        end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                if (pend_wr_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
                state_q <= IDLE;
            end
        end
    end

    assign busy  = state_q == RUN;
    assign stall = d_md_use & (busy | md_op);
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed scoreboard bench for md_ctrl; expected HI/LO/latency are queued at
// issue and popped when the operation completes.
module tb_md_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        d_md_use = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    md_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: 64-bit integer arithmetic, MIPS division rules.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        int    sx, sy;
        longint p;
        logic [63:0] u;
        sx = x;
        sy = y;
        eh = hi_m;
        el = lo_m;
        if (o == 3'd1) begin
            p = longint'(sx) * longint'(sy);
            eh = p[63:32];
            el = p[31:0];
        end else if (o == 3'd2) begin
            u = 64'(x) * 64'(y);
            eh = u[63:32];
            el = u[31:0];
        end else if (o == 3'd3 && y != 0) begin
            p = longint'(sx) / longint'(sy);
            el = p[31:0];
            p = longint'(sx) % longint'(sy);
            eh = p[31:0];
        end else if (o == 3'd4 && y != 0) begin
            el = x / y;
            eh = x % y;
        end
    endtask

    // Called at a negedge; issues one op, runs it to completion and returns at the
    // negedge of the first cycle with busy low. inject>0 drives a stray MULT in that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int n_exp, input logic dmu, input int inject);
        exp_t e;
        int   n, sc;
        sb.push_back('{tag, eh, el, n_exp});
        hi_m = eh;
        lo_m = el;
        d_md_use = dmu;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1 chk({tag, "_issue_stall"}, 32'(stall), 32'(dmu));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        sc = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            if (stall === 1'b1) sc++;
            start = (n == inject);
            if (n == inject) begin
                op = 3'd1;
                a = 32'd5;
                b = 32'd5;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_busy_cycles"}, 32'(n), 32'(e.n));
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        if (dmu) begin
            chk({e.tag, "_stall_cycles"}, 32'(sc), 32'(e.n));
            chk({e.tag, "_stall_done"}, 32'(stall), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] eh, el;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        d_md_use = 1'b1;
        #1 chk("rst_stall", 32'(stall), 32'd0);
        d_md_use = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 0);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b0, 0);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 0);

        start = 1'b1; op = 3'd5; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'd6; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        hi_m = 32'h1234;
        lo_m = 32'h5678;

        run_op("divu_by0", 3'd4, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, 1'b0, 0);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, 0);
        run_op("div_stall", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b1, 3);
        run_op("divu_b2b", 3'd4, 32'd1000, 32'd33, 32'd10, 32'd30, 10, 1'b1, 0);
        d_md_use = 1'b0;

        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        hi_m = '0;
        lo_m = '0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        run_op("multu_after_rst", 3'd2, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            model(ro, ra, rb, eh, el);
            run_op("rand", ro, ra, rb, eh, el, ro >= 3'd3 ? 10 : 5, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
